// File: rtl/fp_addsub_seq_if.sv
// Request/result bundle for the multicycle FP adder/subtractor.
// master drives operands and start; slave (the core) returns result and status.
interface fp_addsub_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
);
    logic             start;
    logic             op;
    logic             s_a;
    logic             s_b;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic [MAN_W-1:0] mant_a;
    logic [MAN_W-1:0] mant_b;

    logic             s_r;
    logic [EXP_W-1:0] exp_r;
    logic [MAN_W-1:0] mant_r;
    logic             done;
    logic             busy;
    logic             zero;
    logic             overflow;
    logic             underflow;

    modport master (
        output start, op, s_a, s_b, exp_a, exp_b, mant_a, mant_b,
        input  s_r, exp_r, mant_r, done, busy, zero, overflow, underflow
    );

    modport slave (
        input  start, op, s_a, s_b, exp_a, exp_b, mant_a, mant_b,
        output s_r, exp_r, mant_r, done, busy, zero, overflow, underflow
    );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multicycle floating-point adder/subtractor with explicit leading-one
// mantissas. Serial alignment (one bit per cycle, collapsed for large gaps),
// serial normalisation, round-to-nearest-even on guard/round/sticky.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input  logic           clk,
    input  logic           rst,
    fp_addsub_seq_if.slave bus
);
    // Working mantissa: {mantissa, G, R, S}
    localparam int          W       = MAN_W + 3;
    localparam int unsigned GAP_MAX = MAN_W + 2;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t state;

    logic             sa, sb, sr;
    logic [EXP_W-1:0] ea, eb, er;
    logic [W-1:0]     ma, mb;
    logic [W:0]       mag;

    logic             sb_eff, a_inf, b_inf, a_zero, b_zero;
    logic             a_big, collapse;
    logic [EXP_W-1:0] diff, er_inc;
    logic [W-1:0]     shr_a, shr_b;
    logic             rnd_inc;
    logic [MAN_W:0]   rnd_sum;

    // Capture decode, alignment step values and rounding increment
    always_comb begin
        sb_eff   = bus.s_b ^ bus.op;
        a_inf    = &bus.exp_a;
        b_inf    = &bus.exp_b;
        a_zero   = (bus.exp_a == '0);
        b_zero   = (bus.exp_b == '0);
        a_big    = (ea > eb);
        diff     = a_big ? (ea - eb) : (eb - ea);
        collapse = (32'(diff) > GAP_MAX);
        shr_a    = {1'b0, ma[W-1:2], ma[1] | ma[0]};
        shr_b    = {1'b0, mb[W-1:2], mb[1] | mb[0]};
        er_inc   = er + 1'b1;
        rnd_inc  = mag[2] & (mag[1] | mag[0] | mag[3]);
        rnd_sum  = {1'b0, mag[W-1:3]} + {{MAN_W{1'b0}}, rnd_inc};
    end

    // Control FSM with registered datapath, result and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            sa            <= 1'b0;
            sb            <= 1'b0;
            sr            <= 1'b0;
            ea            <= '0;
            eb            <= '0;
            er            <= '0;
            ma            <= '0;
            mb            <= '0;
            mag           <= '0;
            bus.s_r       <= 1'b0;
            bus.exp_r     <= '0;
            bus.mant_r    <= '0;
            bus.done      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.zero      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else if ((state == IDLE || state == DONE) && bus.start) begin
            // DONE accepts a new request too, so back-to-back issue is possible
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
            bus.zero      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
            sa            <= bus.s_a;
            sb            <= sb_eff;
            ea            <= bus.exp_a;
            eb            <= bus.exp_b;
            ma            <= {bus.mant_a, 3'b000};
            mb            <= {bus.mant_b, 3'b000};
            if (a_inf || b_inf) begin
                bus.s_r      <= a_inf ? bus.s_a : sb_eff;
                bus.exp_r    <= '1;
                bus.mant_r   <= '0;
                bus.overflow <= 1'b1;
                bus.done     <= 1'b1;
                state        <= DONE;
            end else if (a_zero && b_zero) begin
                bus.s_r    <= bus.s_a & sb_eff;
                bus.exp_r  <= '0;
                bus.mant_r <= '0;
                bus.zero   <= 1'b1;
                bus.done   <= 1'b1;
                state      <= DONE;
            end else if (a_zero) begin
                bus.s_r    <= sb_eff;
                bus.exp_r  <= bus.exp_b;
                bus.mant_r <= bus.mant_b;
                bus.done   <= 1'b1;
                state      <= DONE;
            end else if (b_zero) begin
                bus.s_r    <= bus.s_a;
                bus.exp_r  <= bus.exp_a;
                bus.mant_r <= bus.mant_a;
                bus.done   <= 1'b1;
                state      <= DONE;
            end else begin
                state <= (bus.exp_a == bus.exp_b) ? ADD : ALIGN;
            end
        end else begin
            case (state)
                IDLE: state <= IDLE;
                ALIGN: begin
                    // Only entered with unequal exponents; the step that
                    // equalises them moves straight on to ADD
                    if (a_big) begin
                        if (collapse) begin
                            mb    <= {{(W-1){1'b0}}, |mb};
                            eb    <= ea;
                            state <= ADD;
                        end else begin
                            mb <= shr_b;
                            eb <= eb + 1'b1;
                            if (diff == EXP_W'(1)) state <= ADD;
                        end
                    end else begin
                        if (collapse) begin
                            ma    <= {{(W-1){1'b0}}, |ma};
                            ea    <= eb;
                            state <= ADD;
                        end else begin
                            ma <= shr_a;
                            ea <= ea + 1'b1;
                            if (diff == EXP_W'(1)) state <= ADD;
                        end
                    end
                end
                ADD: begin
                    er <= ea;
                    if (sa == sb) begin
                        mag <= {1'b0, ma} + {1'b0, mb};
                        sr  <= sa;
                    end else if (ma > mb) begin
                        mag <= {1'b0, ma - mb};
                        sr  <= sa;
                    end else if (ma < mb) begin
                        mag <= {1'b0, mb - ma};
                        sr  <= sb;
                    end else begin
                        mag <= '0;
                        sr  <= 1'b0;
                    end
                    state <= NORM;
                end
                NORM: begin
                    if (mag[W]) begin
                        mag <= {1'b0, mag[W:2], mag[1] | mag[0]};
                        er  <= er_inc;
                        if (er_inc == '1) begin
                            bus.s_r      <= sr;
                            bus.exp_r    <= '1;
                            bus.mant_r   <= '0;
                            bus.overflow <= 1'b1;
                            bus.done     <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= ROUND;
                        end
                    end else if (mag == '0) begin
                        bus.s_r    <= sr;
                        bus.exp_r  <= '0;
                        bus.mant_r <= '0;
                        bus.zero   <= 1'b1;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else if (mag[W-1]) begin
                        state <= ROUND;
                    end else if (er == EXP_W'(1)) begin
                        bus.s_r       <= sr;
                        bus.exp_r     <= '0;
                        bus.mant_r    <= '0;
                        bus.zero      <= 1'b1;
                        bus.underflow <= 1'b1;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end else begin
                        mag <= {mag[W-1:0], 1'b0};
                        er  <= er - 1'b1;
                    end
                end
                ROUND: begin
                    bus.s_r <= sr;
                    if (rnd_sum[MAN_W]) begin
                        if (er_inc == '1) begin
                            bus.exp_r    <= '1;
                            bus.mant_r   <= '0;
                            bus.overflow <= 1'b1;
                        end else begin
                            bus.exp_r  <= er_inc;
                            bus.mant_r <= {1'b1, {(MAN_W-1){1'b0}}};
                        end
                    end else begin
                        bus.exp_r  <= er;
                        bus.mant_r <= rnd_sum[MAN_W-1:0];
                    end
                    bus.done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq (EXP_W=8, MAN_W=24) with hand-computed results.
module tb_fp_addsub_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    fp_addsub_seq_if #(.EXP_W(8), .MAN_W(24)) bus ();

    fp_addsub_seq #(.EXP_W(8), .MAN_W(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    task automatic set_ops(input logic sa, input logic [7:0] ea, input logic [23:0] ma,
                           input logic sb, input logic [7:0] eb, input logic [23:0] mb,
                           input logic op);
        bus.s_a = sa; bus.exp_a = ea; bus.mant_a = ma;
        bus.s_b = sb; bus.exp_b = eb; bus.mant_b = mb;
        bus.op  = op;
    endtask

    // Called #1 after the capture edge; counts edges up to the DONE entry edge
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic issue(output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat);
    endtask

    task automatic check_res(input string tag, input logic rs, input logic [7:0] re,
                             input logic [23:0] rm, input logic [2:0] rf,
                             input int rl, input int lat);
        check({tag, ".sign"}, 32'(bus.s_r), 32'(rs));
        check({tag, ".exp"},  32'(bus.exp_r), 32'(re));
        check({tag, ".mant"}, 32'(bus.mant_r), 32'(rm));
        check({tag, ".flags"}, 32'({bus.zero, bus.overflow, bus.underflow}), 32'(rf));
        check({tag, ".lat"},  32'(lat), 32'(rl));
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
    endtask

    task automatic run_vec(input string tag,
                           input logic sa, input logic [7:0] ea, input logic [23:0] ma,
                           input logic sb, input logic [7:0] eb, input logic [23:0] mb,
                           input logic op,
                           input logic rs, input logic [7:0] re, input logic [23:0] rm,
                           input logic [2:0] rf, input int rl);
        int lat;
        set_ops(sa, ea, ma, sb, eb, mb, op);
        issue(lat);
        check_res(tag, rs, re, rm, rf, rl, lat);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, ".busy_end"},   32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  lat;
        logic saw_done;
        bus.start = 1'b0;
        set_ops(1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 24'd0, 1'b0);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.sign", 32'(bus.s_r), 32'd0);
        check("reset.exp",  32'(bus.exp_r), 32'd0);
        check("reset.mant", 32'(bus.mant_r), 32'd0);
        check("reset.ctl",  32'({bus.done, bus.busy, bus.zero, bus.overflow, bus.underflow}), 32'd0);
        @(negedge clk) rst = 1'b1;

        // flags order: {zero, overflow, underflow}
        run_vec("add_same",  0,  8'd1, 24'h800000, 0,   8'd1, 24'h800000, 0,  0,   8'd2, 24'h800000, 3'b000, 4);
        run_vec("tie_up",    0, 8'd10, 24'h800000, 0,   8'd9, 24'h800003, 0,  0,  8'd10, 24'hC00002, 3'b000, 5);
        run_vec("tie_even",  0, 8'd10, 24'h800000, 0,   8'd9, 24'h800001, 0,  0,  8'd10, 24'hC00000, 3'b000, 5);
        run_vec("sub_norm",  0,  8'd5, 24'h800000, 0,   8'd5, 24'hC00000, 1,  1,   8'd4, 24'h800000, 3'b000, 5);
        run_vec("sub_zero",  0,  8'd5, 24'h800000, 0,   8'd5, 24'h800000, 1,  0,   8'd0, 24'h000000, 3'b100, 3);
        run_vec("collapse",  0, 8'd100, 24'h800000, 0, 8'd10, 24'hFFFFFF, 0,  0, 8'd100, 24'h800000, 3'b000, 5);
        run_vec("ovf",       0, 8'd254, 24'hFFFFFF, 0, 8'd254, 24'hFFFFFF, 0, 0, 8'd255, 24'h000000, 3'b010, 3);
        run_vec("unf",       0,  8'd1, 24'hC00000, 0,   8'd1, 24'h800000, 1,  0,   8'd0, 24'h000000, 3'b101, 3);
        run_vec("inf_a",     1, 8'd255, 24'h000000, 0,  8'd3, 24'h800000, 0,  1, 8'd255, 24'h000000, 3'b010, 1);
        run_vec("inf_b",     0,  8'd3, 24'h800000, 0, 8'd255, 24'h000000, 1,  1, 8'd255, 24'h000000, 3'b010, 1);
        run_vec("zero_a",    0,  8'd0, 24'h000000, 0,   8'd7, 24'hA00000, 1,  1,   8'd7, 24'hA00000, 3'b000, 1);
        run_vec("zero_ab",   1,  8'd0, 24'h000000, 0,   8'd0, 24'h000000, 1,  1,   8'd0, 24'h000000, 3'b100, 1);
        run_vec("align2",    0, 8'd12, 24'h800000, 0,  8'd10, 24'h800000, 0,  0,  8'd12, 24'hA00000, 3'b000, 6);
        run_vec("rnd_wrap",  0, 8'd30, 24'hFFFFFF, 0,   8'd6, 24'h800000, 0,  0,  8'd31, 24'h800000, 3'b000, 28);
        run_vec("neg_a",     1, 8'd10, 24'h900000, 0,  8'd10, 24'h800000, 0,  1,   8'd7, 24'h800000, 3'b000, 7);
        run_vec("sub_shift", 0, 8'd10, 24'h800000, 0,   8'd9, 24'h800001, 1,  0,   8'd8, 24'hFFFFFE, 3'b000, 7);

        // Reset during ALIGN: outputs clear at once, no done afterwards
        set_ops(0, 8'd30, 24'hFFFFFF, 0, 8'd6, 24'h800000, 0);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid.exp",  32'(bus.exp_r), 32'd0);
        check("rst_mid.mant", 32'(bus.mant_r), 32'd0);
        check("rst_mid.busy", 32'(bus.busy), 32'd0);
        check("rst_mid.done", 32'(bus.done), 32'd0);
        @(negedge clk) rst = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        check("rst_mid.no_done", 32'(saw_done), 32'd0);

        // start while busy is ignored
        set_ops(0, 8'd30, 24'hFFFFFF, 0, 8'd6, 24'h800000, 0);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        repeat (4) begin
            @(posedge clk); #1;
            lat++;
        end
        set_ops(0, 8'd1, 24'h800000, 0, 8'd1, 24'h800000, 0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        lat++;
        bus.start = 1'b0;
        while (!bus.done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_res("busy_ign", 0, 8'd31, 24'h800000, 3'b000, 28, lat);

        // start sampled on the edge leaving DONE is accepted
        set_ops(0, 8'd1, 24'h800000, 0, 8'd1, 24'h800000, 0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b.busy_held", 32'(bus.busy), 32'd1);
        check("b2b.done_low",  32'(bus.done), 32'd0);
        wait_done(lat);
        check_res("b2b", 0, 8'd2, 24'h800000, 3'b000, 4, lat);
        @(posedge clk); #1;
        check("b2b.done_pulse", 32'(bus.done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
